snn_rate_encoder: RTL and testbench

Input-side rate encoder for the spiking network. It accepts a frame of four unsigned intensities through a valid/ready handshake. Over a fixed window of 2^WIDTH steps it emits one spike bit per channel per step, and the spike count in each channel equals that channel's intensity. Its four spike lanes drive the four input nibble lanes of the SNN core (ch3..ch0 → uio_in[7:4], uio_in[3:0], ui_in[7:4], ui_in[3:0]). A one-deep holding register lets frames run back-to-back.

---
 rtl/snn_rate_encoder.sv | 139 +++++++++++++
 tb/tb_snn_rate_encoder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_rate_encoder.sv
// Four-channel spike rate encoder with a one-deep frame holding register.
// Define SNN_ENC_LFSR_EN for stochastic LFSR-comparator encoding; default is accumulator encoding.
module snn_rate_encoder #(
  parameter int          WIDTH     = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         spike_out,
  output logic               spike_valid,
  output logic               frame_done,
  output logic               busy
);
  localparam int NCH = 4;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t               r_state, w_state_nxt;
  logic [NCH*WIDTH-1:0] r_active, r_hold;
  logic                 r_hold_full;
  logic [WIDTH-1:0]     r_step;
  logic [NCH-1:0]       r_spike, w_spike;
  logic                 r_spike_valid, r_frame_done;
  logic                 w_accept, w_step, w_last;
  logic                 w_load_in, w_load_hold, w_fill_hold, w_load;

  if (LFSR_SEED == 16'h0000) begin : g_seed_chk
    $error("snn_rate_encoder: LFSR_SEED must be non-zero");
  end

  assign in_ready    = !r_hold_full;
  assign w_accept    = in_valid && !r_hold_full;
  assign w_step      = (r_state == S_RUN) && ena;
  assign w_last      = w_step && (r_step == {WIDTH{1'b1}});
  assign w_load      = w_load_in || w_load_hold;
  assign busy        = (r_state == S_RUN);
  assign spike_out   = r_spike;
  assign spike_valid = r_spike_valid;
  assign frame_done  = r_frame_done;

  // A frame offered on the final step with an empty hold goes straight to active (no bubble).
  always_comb begin
    w_state_nxt = r_state;
    w_load_in   = 1'b0;
    w_load_hold = 1'b0;
    w_fill_hold = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_RUN;
          w_load_in   = 1'b1;
        end
      end
      S_RUN: begin
        if (w_last) begin
          if (r_hold_full)   w_load_hold = 1'b1;
          else if (w_accept) w_load_in   = 1'b1;
          else               w_state_nxt = S_IDLE;
        end else if (w_accept) begin
          w_fill_hold = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_hold_full   <= 1'b0;
      r_step        <= '0;
      r_spike       <= '0;
      r_spike_valid <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fill_hold)      r_hold_full <= 1'b1;
      else if (w_load_hold) r_hold_full <= 1'b0;
      if (w_load)           r_step <= '0;
      else if (w_step)      r_step <= r_step + 1'b1;
      r_spike       <= w_step ? w_spike : '0;
      r_spike_valid <= w_step;
      r_frame_done  <= w_last;
    end
  end

  always_ff @(posedge clk) begin
    if (w_load_in)        r_active <= in_data;
    else if (w_load_hold) r_active <= r_hold;
    if (w_fill_hold)      r_hold   <= in_data;
  end

`ifdef SNN_ENC_LFSR_EN
  logic [15:0] r_lfsr;

  if (WIDTH != 4) begin : g_width_chk
    $error("snn_rate_encoder: SNN_ENC_LFSR_EN requires WIDTH == 4");
  end

  // Galois form of x^16+x^14+x^13+x^11+1; runs free across frame boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_lfsr <= LFSR_SEED;
    else if (w_step) r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  always_comb begin
    w_spike = '0;
    for (int c = 0; c < NCH; c++) begin
      w_spike[c] = (r_lfsr[4*c +: 4] < r_active[c*WIDTH +: WIDTH]);
    end
  end
`else
  logic [WIDTH-1:0] r_acc [NCH];
  logic [WIDTH:0]   w_sum [NCH];

  always_comb begin
    w_spike = '0;
    for (int c = 0; c < NCH; c++) begin
      w_sum[c]   = {1'b0, r_acc[c]} + {1'b0, r_active[c*WIDTH +: WIDTH]};
      w_spike[c] = w_sum[c][WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) r_acc[c] <= '0;
    end else if (w_load) begin
      for (int c = 0; c < NCH; c++) r_acc[c] <= '0;
    end else if (w_step) begin
      for (int c = 0; c < NCH; c++) r_acc[c] <= w_sum[c][WIDTH-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_snn_rate_encoder.sv
// Scoreboard bench for snn_rate_encoder (WIDTH=4); follows SNN_ENC_LFSR_EN like the design.
`timescale 1ns/1ps
module tb_snn_rate_encoder;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst_n, ena, in_valid, in_ready;
  logic [15:0] in_data;
  logic [3:0]  spike_out;
  logic        spike_valid, frame_done, busy;

  always #5 clk = ~clk;

  snn_rate_encoder #(.WIDTH(4), .LFSR_SEED(SEED)) u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .spike_out(spike_out), .spike_valid(spike_valid),
    .frame_done(frame_done), .busy(busy)
  );

  typedef struct {
    logic [15:0] d;
    int          k;
  } ent_t;

  ent_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   cnt[4];
  int   exp_cnt3;
  int   run_len, max_run;
  int   done_cyc[$];
`ifdef SNN_ENC_LFSR_EN
  logic [15:0] m_lfsr = SEED;
`endif

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

`ifdef SNN_ENC_LFSR_EN
  function automatic logic [3:0] model_spike(input logic [15:0] d, input logic [15:0] lf);
    logic [3:0] s;
    s = '0;
    for (int c = 0; c < 4; c++)
      s[c] = (int'((lf >> (4*c)) & 16'h000F) < int'((d >> (4*c)) & 16'h000F));
    return s;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic [15:0] n;
    n = v >> 1;
    if (v[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  always @(negedge rst_n) m_lfsr = SEED;
`else
  // Spike at step k iff floor((k+1)*I/16) crosses an integer boundary past floor(k*I/16).
  function automatic logic [3:0] model_spike(input logic [15:0] d, input int k);
    logic [3:0] s;
    int iv;
    s = '0;
    for (int c = 0; c < 4; c++) begin
      iv   = int'((d >> (4*c)) & 16'h000F);
      s[c] = (((k + 1) * iv) / 16) != ((k * iv) / 16);
    end
    return s;
  endfunction
`endif

  always @(posedge clk) cyc++;

  always @(negedge clk) begin : monitor
    ent_t       e;
    logic [3:0] ex;
    if (spike_valid) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'(spike_valid), 32'(0));
      end else begin
        e = sb.pop_front();
`ifdef SNN_ENC_LFSR_EN
        ex     = model_spike(e.d, m_lfsr);
        m_lfsr = lfsr_next(m_lfsr);
`else
        ex = model_spike(e.d, e.k);
`endif
        check("spike", 32'(spike_out), 32'(ex));
        check("frame_done", 32'(frame_done), 32'(e.k == 15));
        for (int c = 0; c < 4; c++) cnt[c] += int'(spike_out[c]);
        exp_cnt3 += int'(ex[3]);
      end
    end else begin
      run_len = 0;
      check("quiet", 32'({frame_done, spike_out}), 32'(0));
    end
    if (frame_done) done_cyc.push_back(cyc);
  end

  task automatic clear_stats();
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    exp_cnt3 = 0;
    max_run  = 0;
    done_cyc.delete();
  endtask

  task automatic send(input logic [15:0] d);
    int t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(0), 32'(1));
      in_valid = 1'b0;
      return;
    end
    for (int k = 0; k < 16; k++) sb.push_back('{d, k});
    @(posedge clk);
    #1 acc_cyc = cyc;
  endtask

  task automatic wait_sb(input int lvl);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      #2 t++;
    end while (sb.size() > lvl && t < 300);
    if (sb.size() > lvl) check("wait_timeout", 32'(sb.size()), 32'(lvl));
  endtask

  initial begin : watchdog
    #300000;
    check("watchdog", 32'(0), 32'(1));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int a_cyc;
    rst_n    = 1'b0;
    ena      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    run_len  = 0;
    clear_stats();
    repeat (3) @(negedge clk);
    check("rst_spike_out", 32'(spike_out), 32'(0));
    check("rst_spike_valid", 32'(spike_valid), 32'(0));
    check("rst_frame_done", 32'(frame_done), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    rst_n = 1'b1;

    // Single frame
    clear_stats();
    send(16'h0F81);
    in_valid = 1'b0;
    check("t1_busy", 32'(busy), 32'(1));
    wait_sb(0);
`ifndef SNN_ENC_LFSR_EN
    check("t1_cnt_ch0", 32'(cnt[0]), 32'(1));
    check("t1_cnt_ch1", 32'(cnt[1]), 32'(8));
    check("t1_cnt_ch2", 32'(cnt[2]), 32'(15));
    check("t1_cnt_ch3", 32'(cnt[3]), 32'(0));
`endif
    check("t1_done_count", 32'(done_cyc.size()), 32'(1));
    if (done_cyc.size() > 0) check("t1_done_latency", 32'(done_cyc[0] - acc_cyc), 32'(16));
    check("t1_idle", 32'(busy), 32'(0));

    // Back-to-back with hold
    clear_stats();
    send(16'h1234);
    a_cyc = acc_cyc;
    send(16'hFEDC);
    in_valid = 1'b0;
    check("t2_ready_low", 32'(in_ready), 32'(0));
    wait_sb(0);
    check("t2_run_len", 32'(max_run), 32'(32));
    check("t2_done_count", 32'(done_cyc.size()), 32'(2));
    if (done_cyc.size() == 2) begin
      check("t2_done_first", 32'(done_cyc[0] - a_cyc), 32'(16));
      check("t2_done_gap", 32'(done_cyc[1] - done_cyc[0]), 32'(16));
    end
    check("t2_ready_back", 32'(in_ready), 32'(1));

    // ena gap after step 6
    clear_stats();
    send(16'h5A3C);
    in_valid = 1'b0;
    wait_sb(9);
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 check("t3_gap_valid", 32'(spike_valid), 32'(0));
    end
    ena = 1'b1;
    wait_sb(0);
    check("t3_done_count", 32'(done_cyc.size()), 32'(1));
    if (done_cyc.size() > 0) check("t3_done_latency", 32'(done_cyc[0] - acc_cyc), 32'(21));

    // Reset at step 9 with hold full
    clear_stats();
    send(16'h7777);
    send(16'h3333);
    in_valid = 1'b0;
    check("t4_hold_full", 32'(in_ready), 32'(0));
    wait_sb(22);
    rst_n = 1'b0;
    #1;
    check("t4_spike_out", 32'(spike_out), 32'(0));
    check("t4_spike_valid", 32'(spike_valid), 32'(0));
    check("t4_frame_done", 32'(frame_done), 32'(0));
    check("t4_busy", 32'(busy), 32'(0));
    check("t4_in_ready", 32'(in_ready), 32'(1));
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("t4_post_busy", 32'(busy), 32'(0));

    // Four F000 frames back-to-back
    clear_stats();
    for (int f = 0; f < 4; f++) send(16'hF000);
    in_valid = 1'b0;
    wait_sb(0);
    check("t5_cnt_ch0", 32'(cnt[0]), 32'(0));
    check("t5_cnt_ch1", 32'(cnt[1]), 32'(0));
    check("t5_cnt_ch2", 32'(cnt[2]), 32'(0));
    check("t5_cnt_ch3", 32'(cnt[3]), 32'(exp_cnt3));
    check("t5_run_len", 32'(max_run), 32'(64));
    check("t5_done_count", 32'(done_cyc.size()), 32'(4));

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
